// File: rtl/ps2_key_event_controller.sv
// Turns the PS/2 scan-code byte stream into {brk, ext, code} key events, tracks modifier
// keys and queues events in a first-word fall-through FIFO for the bus side.
module ps2_key_event_controller #(
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned PREFIX_TIMEOUT = 1250000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    scanCode,
    input  logic                          scanCodeReady,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [9:0]                    evt_data,
    output logic [$clog2(FIFO_DEPTH):0]   evt_count,
    output logic [3:0]                    mods,
    output logic                          overflow,
    input  logic                          overflow_clr
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(PREFIX_TIMEOUT + 1);
    localparam logic [TW-1:0] TimerLast = TW'(PREFIX_TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StExt, StBrk, StExtBrk, StSkip} state_e;

    state_e        state_q, state_d;
    logic [2:0]    skip_q, skip_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    mods_q, mods_d;
    logic          overflow_q, overflow_d;
    logic [CW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [9:0]    mem_q [FIFO_DEPTH];

    logic       emit;
    logic [9:0] emit_data;
    logic       is_e0, is_f0, is_e1, is_prefix, is_ignored;
    logic       full, pop, push;

    assign is_e0      = (scanCode == 8'hE0);
    assign is_f0      = (scanCode == 8'hF0);
    assign is_e1      = (scanCode == 8'hE1);
    assign is_prefix  = is_e0 | is_f0 | is_e1;
    // Receiver status bytes (BAT ok, ACK, resend, echo, errors) never become key events.
    assign is_ignored = (scanCode == 8'hAA) | (scanCode == 8'hFA) | (scanCode == 8'hFE) |
                        (scanCode == 8'hEE) | (scanCode == 8'h00) | (scanCode == 8'hFF);

    always_comb begin
        state_d   = state_q;
        skip_d    = skip_q;
        timer_d   = timer_q;
        emit      = 1'b0;
        emit_data = '0;
        if (scanCodeReady) begin
            timer_d = '0;
            // A fresh E0/E1 inside an extended sequence restarts decoding from idle.
            if (state_q == StIdle || (state_q == StExt && (is_e0 || is_e1))) begin
                state_d = StIdle;
                if (is_e0) begin
                    state_d = StExt;
                end else if (is_f0) begin
                    state_d = StBrk;
                end else if (is_e1) begin
                    state_d = StSkip;
                    skip_d  = 3'd7;
                end else if (!is_ignored) begin
                    emit      = 1'b1;
                    emit_data = {2'b00, scanCode};
                end
            end else begin
                case (state_q)
                    StExt: begin
                        if (is_f0) begin
                            state_d = StExtBrk;
                        end else begin
                            state_d   = StIdle;
                            emit      = 1'b1;
                            emit_data = {2'b01, scanCode};
                        end
                    end
                    StBrk, StExtBrk: begin
                        state_d = StIdle;
                        if (!is_prefix) begin
                            emit      = 1'b1;
                            emit_data = {1'b1, state_q == StExtBrk, scanCode};
                        end
                    end
                    StSkip: begin
                        skip_d = skip_q - 3'd1;
                        if (skip_q == 3'd1) begin
                            state_d   = StIdle;
                            emit      = 1'b1;
                            emit_data = {2'b01, 8'hE1};
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end
        end else if (state_q != StIdle) begin
            if (timer_q == TimerLast) begin
                state_d = StIdle;
                timer_d = '0;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
    end

    always_comb begin
        mods_d = mods_q;
        if (emit) begin
            if (emit_data[7:0] == 8'h12 && !emit_data[8]) mods_d[0] = ~emit_data[9];
            if (emit_data[7:0] == 8'h59 && !emit_data[8]) mods_d[1] = ~emit_data[9];
            if (emit_data[7:0] == 8'h14)                  mods_d[2] = ~emit_data[9];
            if (emit_data[7:0] == 8'h11)                  mods_d[3] = ~emit_data[9];
        end
    end

    assign evt_count = wr_q - rd_q;
    assign evt_valid = (evt_count != '0);
    assign full      = (evt_count == CW'(FIFO_DEPTH));
    assign pop       = evt_valid & evt_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push      = emit & (~full | pop);
    assign evt_data  = evt_valid ? mem_q[rd_q[AW-1:0]] : '0;
    assign mods      = mods_q;
    assign overflow  = overflow_q;

    always_comb begin
        wr_d       = wr_q + CW'(push);
        rd_d       = rd_q + CW'(pop);
        overflow_d = overflow_q;
        if (overflow_clr) overflow_d = 1'b0;
        if (emit && full && !pop) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            skip_q     <= '0;
            timer_q    <= '0;
            mods_q     <= '0;
            overflow_q <= 1'b0;
            wr_q       <= '0;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            skip_q     <= skip_d;
            timer_q    <= timer_d;
            mods_q     <= mods_d;
            overflow_q <= overflow_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= emit_data;
    end

endmodule
